input_sequencer: RTL and testbench
==================================

# input_sequencer

Prefetching read controller between the CPU's IN1/IN2 input ports and the two-channel input stream source. The source's read pointers only advance on `src_adv` pulses, and its data is registered. This block primes each channel after reset and advances the pointers as words are consumed. It buffers up to two words per channel so the CPU sees single-cycle reads, and it signals stall and end-of-stream per channel.

## Interface
Parameters:
- `DW`, 12: data width of both channels.
- `LEN1`, 16: number of words in channel-1 stream (0..255).
- `LEN2`, 9: number of words in channel-2 stream (0..255).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high. Also resets the source, so both pointers are 0.
- `cpu_rd1`, `cpu_rd2`  in  1 each  pop head word of channel 1/2 this cycle.
- `cpu_data1`, `cpu_data2`  out  DW each  head word of buffer; 0 when empty.
- `cpu_vld1`, `cpu_vld2`  out  1 each  buffer non-empty.
- `cpu_eos1`, `cpu_eos2`  out  1 each  all LEN words captured and buffer empty.
- `stall`  out  1  combinational; a requested read cannot complete this cycle.
- `src_adv1`, `src_adv2`  out  1 each  advance source pointer; combinational (Mealy).
- `src_data1`, `src_data2`  in  DW each  registered source data.

## Operation
- The two channels are identical and fully independent. Each channel has:
  - a fetch FSM;
  - a 2-entry FIFO, `occ` 0..2;
  - a capture counter `cnt`, 8 bits, 0..LEN.
- FSM states:
  - PRIME: first cycle after reset. Unconditionally goes to READY.
  - READY: `src_data` holds the next uncaptured word. A capture occurs when `cnt<LEN` and (`occ<2`, or a pop this cycle).
    - On capture: write `src_data` to FIFO tail and increment `cnt`.
    - If the new `cnt<LEN`, assert `src_adv` this cycle and go to WAIT.
    - Otherwise go to DONE.
    - If no capture, stay in READY with `src_adv` low.
  - WAIT: one cycle, letting the source register the new word. Goes to READY.
  - DONE: terminal until reset. `src_adv` stays low.
- If LEN=0, PRIME goes directly to DONE.
- Pop: `cpu_rd` with `occ>0` removes the head. Pop and capture in the same cycle leave `occ` unchanged. When full, the popped slot is reused in that cycle.
- A read on an empty FIFO depends on `cpu_eos`:
  - `cpu_eos=0`: `stall=1`, nothing is popped, and the CPU must hold `cpu_rd` and retry.
  - `cpu_eos=1`: no stall, `cpu_data=0`, and no state change.
- `stall = (rd1 & ~vld1 & ~eos1) | (rd2 & ~vld2 & ~eos2)`. One stalled channel does not block a pop on the other channel in the same cycle.
- `src_adv` is never asserted more than LEN-1 times per channel per reset. `src_adv` is never asserted in two consecutive cycles.

## Timing
- Reset values:
  - FSM=PRIME, `occ=0`, `cnt=0`.
  - `cpu_vld`=0 and `cpu_data`=0 for both channels.
  - `cpu_eos=0`, except 1 from the cycle after reset when LEN=0.
  - `src_adv`=0 and `stall`=0 while `rst` is high.
- Cycle numbering: cycle 0 is the first cycle with `rst` low.
  - cycle 0: PRIME.
  - cycle 1: first capture; `src_adv` high if LEN>1.
  - cycle 2: `cpu_vld` high.
- Capture in cycle k with `src_adv` means the next word is captured in cycle k+2 at the earliest. Peak fill rate is 1 word per 2 cycles per channel.
- A popped word leaves the head at the next edge, and the new head is visible in the following cycle.
- `cpu_eos` rises in the cycle after the pop that empties the FIFO in DONE.
- Reset mid-operation: `rst` on any edge discards FIFO contents and counters and restarts from PRIME. Any `src_adv` in a cycle with `rst` high is forced low.

## Test plan
- Single-read sequence, one read every cycle with `stall` honoured (LEN1=16; source channel 1 = 005,001,005,007,001,002,009,008,...):
  - the CPU sees 005 in cycle 2 and then each word in order;
  - after 16 words `cpu_eos1=1` and `src_adv1` was pulsed exactly 15 times.
- No reads for 20 cycles:
  - `occ1`=`occ2`=2 and `src_adv` is pulsed exactly twice per channel;
  - back-to-back reads then return 005,001 (ch1) and 003,FFD (ch2) with no stall on the first two.
- Simultaneous pop and capture when full:
  - `occ` stays 2;
  - no word is lost or duplicated across all 9 channel-2 words: 003,FFD,FFD,004,FFC,001,FFD,FFC,003.
- Read on empty FIFO:
  - `stall=1` with no pop while `cpu_vld` is low;
  - after exhaustion, a read returns 000 with `stall=0`.
- LEN2=0 and LEN1=1:
  - ch2 `cpu_eos2=1` from cycle 1 and `src_adv2` never fires;
  - ch1 captures 005 with no `src_adv1`, then reaches eos after one pop.
- `rst` asserted in the middle of a channel-1 fetch:
  - all outputs return to their reset values;
  - the stream restarts at 005 in cycle 2 after release.

Source files
------------

// File: rtl/input_sequencer.sv
// Two-channel prefetching read controller between the CPU IN1/IN2 ports and
// a registered, pointer-advanced input stream source.

module input_sequencer_chan #(
    parameter int unsigned DW  = 12,
    parameter int unsigned LEN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic [DW-1:0] src_data,
    output logic [DW-1:0] data,
    output logic          vld,
    output logic          eos,
    output logic          stall_c,
    output logic          adv_c
);
    localparam logic [7:0] LEN8 = 8'(LEN);
    localparam logic [8:0] LEN9 = 9'(LEN);

    typedef enum logic [1:0] {PRIME, READY, WAIT, DONE} state_t;

    state_t        state;
    logic [1:0]    occ;
    logic [7:0]    cnt;
    logic [DW-1:0] slot1;

    logic          pop;
    logic          capture;
    logic          last;
    logic          done_n;
    logic [1:0]    occ_n;
    logic [DW-1:0] head_n;
    logic [DW-1:0] slot1_n;

    // Mealy decode plus next FIFO contents; data register doubles as the FIFO head
    always_comb begin
        pop      = rd && (occ != 2'd0);
        capture  = (state == READY) && (cnt < LEN8) && ((occ != 2'd2) || pop);
        last     = ({1'b0, cnt} + 9'd1) >= LEN9;
        adv_c    = !rst && capture && !last;
        stall_c  = !rst && rd && !vld && !eos;
        done_n   = (state == DONE) || (capture && last) || ((state == PRIME) && (LEN8 == 8'd0));
        occ_n    = occ;
        head_n   = data;
        slot1_n  = slot1;
        if (pop && capture) begin
            if (occ == 2'd2) begin
                head_n  = slot1;
                slot1_n = src_data;
            end else begin
                head_n  = src_data;
            end
        end else if (pop) begin
            occ_n  = occ - 2'd1;
            head_n = (occ == 2'd2) ? slot1 : '0;
        end else if (capture) begin
            occ_n = occ + 2'd1;
            if (occ == 2'd0) head_n  = src_data;
            else             slot1_n = src_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PRIME;
            occ   <= 2'd0;
            cnt   <= 8'd0;
            data  <= '0;
            slot1 <= '0;
            vld   <= 1'b0;
            eos   <= 1'b0;
        end else begin
            case (state)
                PRIME:   state <= (LEN8 == 8'd0) ? DONE : READY;
                READY:   if (capture) state <= last ? DONE : WAIT;
                WAIT:    state <= READY;
                default: state <= DONE;
            endcase
            if (capture) cnt <= cnt + 8'd1;
            occ   <= occ_n;
            data  <= head_n;
            slot1 <= slot1_n;
            vld   <= (occ_n != 2'd0);
            eos   <= done_n && (occ_n == 2'd0);
        end
    end
endmodule

module input_sequencer #(
    parameter int unsigned DW   = 12,
    parameter int unsigned LEN1 = 16,
    parameter int unsigned LEN2 = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rd1,
    input  logic          cpu_rd2,
    output logic [DW-1:0] cpu_data1,
    output logic [DW-1:0] cpu_data2,
    output logic          cpu_vld1,
    output logic          cpu_vld2,
    output logic          cpu_eos1,
    output logic          cpu_eos2,
    output logic          stall,
    output logic          src_adv1,
    output logic          src_adv2,
    input  logic [DW-1:0] src_data1,
    input  logic [DW-1:0] src_data2
);
    logic stall1;
    logic stall2;

    input_sequencer_chan #(.DW(DW), .LEN(LEN1)) u_ch1 (
        .clk      (clk),
        .rst      (rst),
        .rd       (cpu_rd1),
        .src_data (src_data1),
        .data     (cpu_data1),
        .vld      (cpu_vld1),
        .eos      (cpu_eos1),
        .stall_c  (stall1),
        .adv_c    (src_adv1)
    );

    input_sequencer_chan #(.DW(DW), .LEN(LEN2)) u_ch2 (
        .clk      (clk),
        .rst      (rst),
        .rd       (cpu_rd2),
        .src_data (src_data2),
        .data     (cpu_data2),
        .vld      (cpu_vld2),
        .eos      (cpu_eos2),
        .stall_c  (stall2),
        .adv_c    (src_adv2)
    );

    assign stall = stall1 | stall2;
endmodule

// File: tb/tb_input_sequencer.sv
// Bench for input_sequencer: directed table on a LEN1=1/LEN2=0 instance, directed
// sequences and randomized reads on a LEN1=16/LEN2=9 instance against a queue model.
`timescale 1ns/1ps
module tb_input_sequencer;
    localparam int unsigned DW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_rd1, a_rd2, b_rd1, b_rd2;
    logic [DW-1:0] a_d1, a_d2, b_d1, b_d2;
    logic [DW-1:0] a_s1, a_s2, b_s1, b_s2;
    logic          a_v1, a_v2, a_e1, a_e2, a_st, a_adv1, a_adv2;
    logic          b_v1, b_v2, b_e1, b_e2, b_st, b_adv1, b_adv2;
    logic [7:0]    a_p1, a_p2, b_p1, b_p2;
    logic [DW-1:0] w1 [16];
    logic [DW-1:0] w2 [9];

    input_sequencer #(.DW(DW), .LEN1(16), .LEN2(9)) dut_a (
        .clk(clk), .rst(rst), .cpu_rd1(a_rd1), .cpu_rd2(a_rd2),
        .cpu_data1(a_d1), .cpu_data2(a_d2), .cpu_vld1(a_v1), .cpu_vld2(a_v2),
        .cpu_eos1(a_e1), .cpu_eos2(a_e2), .stall(a_st),
        .src_adv1(a_adv1), .src_adv2(a_adv2), .src_data1(a_s1), .src_data2(a_s2)
    );

    input_sequencer #(.DW(DW), .LEN1(1), .LEN2(0)) dut_b (
        .clk(clk), .rst(rst), .cpu_rd1(b_rd1), .cpu_rd2(b_rd2),
        .cpu_data1(b_d1), .cpu_data2(b_d2), .cpu_vld1(b_v1), .cpu_vld2(b_v2),
        .cpu_eos1(b_e1), .cpu_eos2(b_e2), .stall(b_st),
        .src_adv1(b_adv1), .src_adv2(b_adv2), .src_data1(b_s1), .src_data2(b_s2)
    );

    // Source streams: pointers move only on src_adv, data follows the registered pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            a_p1 <= 8'd0; a_p2 <= 8'd0; b_p1 <= 8'd0; b_p2 <= 8'd0;
        end else begin
            if (a_adv1) a_p1 <= a_p1 + 8'd1;
            if (a_adv2) a_p2 <= a_p2 + 8'd1;
            if (b_adv1) b_p1 <= b_p1 + 8'd1;
            if (b_adv2) b_p2 <= b_p2 + 8'd1;
        end
    end
    assign a_s1 = (a_p1 < 8'd16) ? w1[a_p1[3:0]] : '0;
    assign a_s2 = (a_p2 < 8'd9)  ? w2[a_p2[3:0]] : '0;
    assign b_s1 = (b_p1 < 8'd16) ? w1[b_p1[3:0]] : '0;
    assign b_s2 = (b_p2 < 8'd9)  ? w2[b_p2[3:0]] : '0;

    int n_chk  = 0;
    int n_pass = 0;
    int b_adv2_cnt = 0;

    always @(negedge clk) if (b_adv2) b_adv2_cnt++;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model of dut_a: per channel a 2-deep word queue, captured count and
    // earliest cycle the next capture may happen.
    int qd [2][2];
    int qn [2];
    int cap[2];
    int nxt[2];
    int t;

    task automatic model_check();
        int len, rd, ev, ed, ee, pop, capn, eadv, e_stall;
        int v_a, d_a, e_a, adv_a;
        if (rst) begin
            chk("rst_stall", int'(a_st), 0);
            chk("rst_adv1", int'(a_adv1), 0);
            chk("rst_adv2", int'(a_adv2), 0);
            for (int ch = 0; ch < 2; ch++) begin
                qn[ch] = 0; cap[ch] = 0; nxt[ch] = 1;
            end
            t = 0;
            return;
        end
        e_stall = 0;
        for (int ch = 0; ch < 2; ch++) begin
            len   = (ch == 1) ? 9 : 16;
            rd    = (ch == 1) ? int'(a_rd2) : int'(a_rd1);
            v_a   = (ch == 1) ? int'(a_v2) : int'(a_v1);
            d_a   = (ch == 1) ? int'(a_d2) : int'(a_d1);
            e_a   = (ch == 1) ? int'(a_e2) : int'(a_e1);
            adv_a = (ch == 1) ? int'(a_adv2) : int'(a_adv1);
            ev    = (qn[ch] > 0) ? 1 : 0;
            ed    = (ev == 1) ? qd[ch][0] : 0;
            ee    = (t >= 1 && cap[ch] == len && qn[ch] == 0) ? 1 : 0;
            pop   = (rd == 1 && qn[ch] > 0) ? 1 : 0;
            capn  = (t >= nxt[ch] && cap[ch] < len && (qn[ch] < 2 || pop == 1)) ? 1 : 0;
            eadv  = (capn == 1 && cap[ch] + 1 < len) ? 1 : 0;
            if (rd == 1 && ev == 0 && ee == 0) e_stall = 1;
            chk((ch == 1) ? "m_vld2" : "m_vld1", v_a, ev);
            chk((ch == 1) ? "m_data2" : "m_data1", d_a, ed);
            chk((ch == 1) ? "m_eos2" : "m_eos1", e_a, ee);
            chk((ch == 1) ? "m_adv2" : "m_adv1", adv_a, eadv);
            if (pop == 1) begin
                qd[ch][0] = qd[ch][1];
                qn[ch]--;
            end
            if (capn == 1) begin
                qd[ch][qn[ch]] = (ch == 1) ? int'(w2[cap[ch]]) : int'(w1[cap[ch]]);
                qn[ch]++;
                cap[ch]++;
                nxt[ch] = t + 2;
            end
        end
        chk("m_stall", int'(a_st), e_stall);
        t++;
    endtask

    task automatic go(input logic r, input logic x1, input logic x2, input logic y1, input logic y2);
        rst = r; a_rd1 = x1; a_rd2 = x2; b_rd1 = y1; b_rd2 = y2;
        @(negedge clk);
        model_check();
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rd1, rd2;
        logic [DW-1:0] d1;
        logic          v1, e1, e2, a1, a2, st;
    } vec_t;

    vec_t          tbl[6];
    int            n1, n2, nw, nadv, first, done;
    logic [DW-1:0] got[16];
    logic          h1, h2, r, x1, x2;
    int            bias;

    initial begin
        w1 = '{12'h005, 12'h001, 12'h005, 12'h007, 12'h001, 12'h002, 12'h009, 12'h008,
               12'h003, 12'h00A, 12'hFFF, 12'h006, 12'h004, 12'h000, 12'h00B, 12'h002};
        w2 = '{12'h003, 12'hFFD, 12'hFFD, 12'h004, 12'hFFC, 12'h001, 12'hFFD, 12'hFFC, 12'h003};
        //           rd1 rd2 d1      v1 e1 e2 a1 a2 st
        tbl[0] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 12'h005, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rst = 1'b1; a_rd1 = 1'b0; a_rd2 = 1'b0; b_rd1 = 1'b0; b_rd2 = 1'b0;
        @(posedge clk); #1;

        go(1, 0, 0, 0, 0); fin();
        go(1, 0, 0, 0, 0);
        chk("rst_vld1", int'(a_v1), 0);  chk("rst_vld2", int'(a_v2), 0);
        chk("rst_data1", int'(a_d1), 0); chk("rst_data2", int'(a_d2), 0);
        chk("rst_eos1", int'(a_e1), 0);  chk("rst_eos2", int'(a_e2), 0);
        chk("rst_b_eos2", int'(b_e2), 0); chk("rst_b_stall", int'(b_st), 0);
        fin();

        // LEN1=1 / LEN2=0 instance, cycle by cycle after reset release
        foreach (tbl[i]) begin
            go(0, 0, 0, tbl[i].rd1, tbl[i].rd2);
            chk($sformatf("tb%0d_data1", i), int'(b_d1), int'(tbl[i].d1));
            chk($sformatf("tb%0d_vld1", i), int'(b_v1), int'(tbl[i].v1));
            chk($sformatf("tb%0d_eos1", i), int'(b_e1), int'(tbl[i].e1));
            chk($sformatf("tb%0d_eos2", i), int'(b_e2), int'(tbl[i].e2));
            chk($sformatf("tb%0d_adv1", i), int'(b_adv1), int'(tbl[i].a1));
            chk($sformatf("tb%0d_adv2", i), int'(b_adv2), int'(tbl[i].a2));
            chk($sformatf("tb%0d_stall", i), int'(b_st), int'(tbl[i].st));
            chk($sformatf("tb%0d_d2", i), int'(b_d2), 0);
            chk($sformatf("tb%0d_v2", i), int'(b_v2), 0);
            fin();
        end

        // No reads for 20 cycles: both FIFOs fill with exactly two advances each
        go(1, 0, 0, 0, 0); fin();
        n1 = 0; n2 = 0;
        for (int c = 0; c < 20; c++) begin
            go(0, 0, 0, 0, 0);
            if (a_adv1) n1++;
            if (a_adv2) n2++;
            fin();
        end
        chk("idle_adv1", n1, 2);
        chk("idle_adv2", n2, 2);
        go(0, 1, 1, 0, 0);
        chk("b2b_d1_0", int'(a_d1), 12'h005); chk("b2b_d2_0", int'(a_d2), 12'h003);
        chk("b2b_st_0", int'(a_st), 0);
        fin();
        go(0, 1, 1, 0, 0);
        chk("b2b_d1_1", int'(a_d1), 12'h001); chk("b2b_d2_1", int'(a_d2), 12'hFFD);
        chk("b2b_st_1", int'(a_st), 0);
        fin();
        go(0, 0, 0, 0, 0); fin();

        // Reset in the middle of a channel-1 fetch
        go(1, 0, 0, 0, 0); fin();
        go(1, 0, 0, 0, 0);
        chk("mid_rst_vld1", int'(a_v1), 0); chk("mid_rst_data1", int'(a_d1), 0);
        chk("mid_rst_eos1", int'(a_e1), 0); chk("mid_rst_vld2", int'(a_v2), 0);
        fin();

        // Single-read sequence: rd1 held every cycle, stalls retried
        nw = 0; nadv = 0; first = -1; done = 0;
        for (int c = 0; c < 200 && done == 0; c++) begin
            go(0, 1, 0, 0, 0);
            if (a_adv1) nadv++;
            if (a_v1) begin
                if (nw < 16) got[nw] = a_d1;
                if (nw == 0) first = c;
                nw++;
            end
            done = int'(a_e1);
            fin();
        end
        chk("seq_eos1", done, 1);
        chk("seq_first_cycle", first, 2);
        chk("seq_words", nw, 16);
        chk("seq_adv1", nadv, 15);
        for (int i = 0; i < 16; i++) chk($sformatf("seq_w%0d", i), int'(got[i]), int'(w1[i]));
        go(0, 1, 0, 0, 0);
        chk("exh_data1", int'(a_d1), 0); chk("exh_stall", int'(a_st), 0);
        chk("exh_eos1", int'(a_e1), 1);
        fin();

        // Channel 2 starts full, then pops every cycle (pop+capture while full)
        go(1, 0, 0, 0, 0); fin();
        for (int c = 0; c < 8; c++) begin go(0, 0, 0, 0, 0); fin(); end
        nw = 0; done = 0;
        for (int c = 0; c < 100 && done == 0; c++) begin
            go(0, 0, 1, 0, 0);
            if (a_v2) begin
                if (nw < 16) got[nw] = a_d2;
                nw++;
            end
            done = int'(a_e2);
            fin();
        end
        chk("ch2_eos2", done, 1);
        chk("ch2_words", nw, 9);
        for (int i = 0; i < 9; i++) chk($sformatf("ch2_w%0d", i), int'(got[i]), int'(w2[i]));

        // Randomized reads (stall honoured) with occasional resets
        h1 = 1'b0; h2 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 256 == 0) bias = int'($urandom_range(0, 3));
            r  = ($urandom_range(0, 199) == 0);
            x1 = h1 || ($urandom_range(0, 3) < bias);
            x2 = h2 || ($urandom_range(0, 3) < bias);
            go(r, x1, x2, 0, 0);
            h1 = !r && a_rd1 && !a_v1 && !a_e1;
            h2 = !r && a_rd2 && !a_v2 && !a_e2;
            fin();
        end

        chk("b_adv2_never", b_adv2_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
